add_cp: RTL and testbench

ADD_CP -- requirements
Module: add_cp

---
 rtl/add_cp.sv | 112 +++++++++++
 tb/tb_add_cp.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_cp.sv
// add_cp: cyclic-prefix inserter turning each 64-sample symbol into 80 samples (x[48..63] then x[0..63]).
// Optional build macro ADD_CP_WINDOW_EN blends the first prefix sample with sample 0 of the previous symbol.
module add_cp (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic [31:0] DAT_I,
   input  logic        WE_I,
   input  logic        STB_I,
   input  logic        CYC_I,
   output logic        ACK_O,
   output logic [31:0] DAT_O,
   output logic        WE_O,
   output logic        STB_O,
   output logic        CYC_O,
   input  logic        ACK_I
);
   typedef enum logic [1:0] {IDLE, LOAD, EMIT_CP, EMIT_SYM} state_t;
   state_t      state, state_n;
   logic [5:0]  count, count_n, rd, rd_n;
   logic [31:0] dat_n, first;
   logic        stb_n, cyc_n, in_xfer, out_xfer;
   logic [31:0] buf_mem [64];
   logic        unused_we;
   assign unused_we = WE_I;
   assign ACK_O    = (state == LOAD) & STB_I & CYC_I;
   assign in_xfer  = ACK_O;
   assign out_xfer = STB_O & ACK_I;
   assign WE_O     = STB_O;
`ifdef ADD_CP_WINDOW_EN
   logic [31:0] prev, prev_n;
   function automatic logic [15:0] half_sum(input logic [15:0] a, input logic [15:0] b);
      half_sum = ($signed(a) >>> 1) + ($signed(b) >>> 1);
   endfunction
   assign first = {half_sum(buf_mem[48][31:16], prev[31:16]), half_sum(buf_mem[48][15:0], prev[15:0])};
   // sample 0 of the previous symbol in this frame; cleared whenever the frame ends
   always_ff @(posedge CLK_I or negedge RST_I)
      if (!RST_I) prev <= '0;
      else prev <= prev_n;
`else
   assign first = buf_mem[48];
`endif
   // next-state, counters and the registered output sample
   always_comb begin
      state_n = state;
      count_n = count;
      rd_n    = rd;
      dat_n   = DAT_O;
      stb_n   = STB_O;
`ifdef ADD_CP_WINDOW_EN
      prev_n  = prev;
`endif
      case (state)
         IDLE: if (CYC_I) state_n = LOAD;
         LOAD: begin
            if (!CYC_I) begin
               state_n = IDLE;
               count_n = '0;
            end else if (in_xfer) begin
               count_n = count + 6'd1;
               if (count == 6'd63) begin
                  state_n = EMIT_CP;
                  rd_n    = 6'd48;
                  dat_n   = first;
                  stb_n   = 1'b1;
`ifdef ADD_CP_WINDOW_EN
                  prev_n  = buf_mem[0];
`endif
               end
            end
         end
         EMIT_CP: if (out_xfer) begin
            rd_n  = rd + 6'd1;
            dat_n = buf_mem[rd_n];
            if (rd == 6'd63) state_n = EMIT_SYM;
         end
         EMIT_SYM: if (out_xfer) begin
            rd_n  = rd + 6'd1;
            dat_n = buf_mem[rd_n];
            if (rd == 6'd63) begin
               state_n = LOAD;
               stb_n   = 1'b0;
            end
         end
      endcase
      cyc_n = stb_n | (CYC_O & CYC_I);
`ifdef ADD_CP_WINDOW_EN
      if (state_n == IDLE) prev_n = '0;
`endif
   end
   // state register
   always_ff @(posedge CLK_I or negedge RST_I)
      if (!RST_I) state <= IDLE;
      else state <= state_n;
   // counters and downstream output registers
   always_ff @(posedge CLK_I or negedge RST_I)
      if (!RST_I) begin
         count <= '0;
         rd    <= '0;
         DAT_O <= '0;
         STB_O <= 1'b0;
         CYC_O <= 1'b0;
      end else begin
         count <= count_n;
         rd    <= rd_n;
         DAT_O <= dat_n;
         STB_O <= stb_n;
         CYC_O <= cyc_n;
      end
   // symbol buffer, written only by accepted input transfers
   always_ff @(posedge CLK_I)
      if (in_xfer) buf_mem[count] <= DAT_I;
endmodule

// File: tb/tb_add_cp.sv
// tb_add_cp: scoreboard bench for add_cp covering ramp, backpressure, back-to-back, abort and reset cases.
module tb_add_cp;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [31:0] up_dat = '0, dn_dat;
   logic        up_we = 1'b1, up_stb = 1'b0, up_cyc = 1'b0, up_ack;
   logic        dn_we, dn_stb, dn_cyc, dn_ack = 1'b1;
   int          checks = 0, errors = 0;
   logic [31:0] exp_q[$], stim_q[$], got_q[$];
   logic [31:0] sym [64];
   logic [31:0] mprev = '0;
   int          first_out, last_out, in64, hold_err, ack_err;
   bit          timeout;

   add_cp dut (
      .CLK_I(clk), .RST_I(rst_n), .DAT_I(up_dat), .WE_I(up_we), .STB_I(up_stb), .CYC_I(up_cyc),
      .ACK_O(up_ack), .DAT_O(dn_dat), .WE_O(dn_we), .STB_O(dn_stb), .CYC_O(dn_cyc), .ACK_I(dn_ack)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] half(input logic [15:0] a, input logic [15:0] b);
      int s;
      s = (int'($signed(a)) >>> 1) + (int'($signed(b)) >>> 1);
      return s[15:0];
   endfunction

   // queue inputs of sym and the 80 outputs it must produce
   function automatic void push_symbol();
      logic [31:0] f;
      f = sym[48];
`ifdef ADD_CP_WINDOW_EN
      f = {half(sym[48][31:16], mprev[31:16]), half(sym[48][15:0], mprev[15:0])};
      mprev = sym[0];
`endif
      exp_q.push_back(f);
      for (int k = 49; k < 64; k++) exp_q.push_back(sym[k]);
      for (int k = 0; k < 64; k++) exp_q.push_back(sym[k]);
      for (int k = 0; k < 64; k++) stim_q.push_back(sym[k]);
   endfunction

   function automatic void rand_symbol();
      for (int k = 0; k < 64; k++) sym[k] = $urandom();
   endfunction

   // drive n_in inputs from stim_q and collect downstream transfers until n_out arrive
   task automatic run(input int n_in, input int n_out, input bit toggle, input int budget);
      int cyc = 0, sent = 0;
      bit pend = 0;
      logic [31:0] pdat = '0;
      got_q.delete();
      first_out = -1; last_out = -1; in64 = -1; hold_err = 0; ack_err = 0; timeout = 0;
      while (sent < n_in || got_q.size() < n_out) begin
         if (cyc == budget) begin
            timeout = 1;
            break;
         end
         @(posedge clk); #1;
         up_stb = sent < n_in;
         up_cyc = sent < n_in;
         up_dat = sent < n_in ? stim_q[0] : 32'h0;
         dn_ack = !toggle || (cyc % 2 == 0);
         #1;
         if (pend && (!dn_stb || dn_dat !== pdat)) hold_err++;
         if (up_ack && dn_stb) ack_err++;
         pend = dn_stb && !dn_ack;
         pdat = dn_dat;
         if (up_stb && up_cyc && up_ack) begin
            void'(stim_q.pop_front());
            sent++;
            if (sent == 64 && in64 < 0) in64 = cyc;
         end
         if (dn_stb && dn_ack) begin
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            got_q.push_back(dn_dat);
         end
         cyc++;
      end
   endtask

   task automatic test_reset();
      #2;
      checks += 5;
      if (dn_stb !== 1'b0) begin errors++; $display("FAIL reset stb: got %b expected 0", dn_stb); end
      if (dn_we !== 1'b0) begin errors++; $display("FAIL reset we: got %b expected 0", dn_we); end
      if (dn_cyc !== 1'b0) begin errors++; $display("FAIL reset cyc: got %b expected 0", dn_cyc); end
      if (up_ack !== 1'b0) begin errors++; $display("FAIL reset ack: got %b expected 0", up_ack); end
      if (dn_dat !== 32'h0) begin errors++; $display("FAIL reset dat: got %h expected 0", dn_dat); end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_ramp();
      logic [31:0] e;
      int n;
      mprev = '0;
      for (int k = 0; k < 64; k++) sym[k] = {k[15:0], k[15:0]};
      push_symbol();
      run(64, 80, 0, 1000);
      checks += 5;
      if (timeout) begin errors++; $display("FAIL ramp timeout: got %0d outputs expected 80", got_q.size()); end
      if (first_out != in64 + 1) begin errors++; $display("FAIL ramp latency: got %0d expected %0d", first_out, in64 + 1); end
      if (last_out - first_out != 79) begin errors++; $display("FAIL ramp span: got %0d expected 79", last_out - first_out); end
      if (got_q.size() != 80) begin errors++; $display("FAIL ramp count: got %0d expected 80", got_q.size()); end
      if (dn_cyc !== 1'b1) begin errors++; $display("FAIL ramp cyc_last: got %b expected 1", dn_cyc); end
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q[k] !== e) begin errors++; $display("FAIL ramp[%0d]: got %h expected %h", k, got_q[k], e); end
      end
      @(posedge clk); #2;
      checks += 2;
      if (dn_stb !== 1'b0) begin errors++; $display("FAIL ramp stb_after: got %b expected 0", dn_stb); end
      if (dn_cyc !== 1'b0) begin errors++; $display("FAIL ramp cyc_after: got %b expected 0", dn_cyc); end
   endtask

   task automatic test_backpressure();
      logic [31:0] e;
      int n;
      mprev = '0;
      for (int k = 0; k < 64; k++) sym[k] = {k[15:0], k[15:0]};
      push_symbol();
      rand_symbol();
      push_symbol();
      run(128, 160, 1, 3000);
      checks += 4;
      if (timeout) begin errors++; $display("FAIL bp timeout: got %0d outputs expected 160", got_q.size()); end
      if (got_q.size() != 160) begin errors++; $display("FAIL bp count: got %0d expected 160", got_q.size()); end
      if (hold_err != 0) begin errors++; $display("FAIL bp hold: got %0d unstable stalls expected 0", hold_err); end
      if (ack_err != 0) begin errors++; $display("FAIL bp ack_during_emit: got %0d expected 0", ack_err); end
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q[k] !== e) begin errors++; $display("FAIL bp[%0d]: got %h expected %h", k, got_q[k], e); end
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      int n;
      mprev = '0;
      rand_symbol();
      push_symbol();
      rand_symbol();
      push_symbol();
      run(128, 160, 0, 2000);
      checks += 3;
      if (timeout) begin errors++; $display("FAIL b2b timeout: got %0d outputs expected 160", got_q.size()); end
      if (got_q.size() != 160) begin errors++; $display("FAIL b2b count: got %0d expected 160", got_q.size()); end
      if (dn_cyc !== 1'b1) begin errors++; $display("FAIL b2b cyc_last: got %b expected 1", dn_cyc); end
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q[k] !== e) begin errors++; $display("FAIL b2b[%0d]: got %h expected %h", k, got_q[k], e); end
      end
      @(posedge clk); #2;
      checks++;
      if (dn_cyc !== 1'b0) begin errors++; $display("FAIL b2b cyc_fall: got %b expected 0", dn_cyc); end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_abort();
      logic [31:0] e;
      int n, stb_seen = 0;
      stim_q.delete();
      for (int k = 0; k < 30; k++) stim_q.push_back($urandom());
      run(30, 0, 0, 500);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         up_stb = 1'b0;
         up_cyc = 1'b0;
         #1;
         if (dn_stb) stb_seen++;
      end
      checks += 2;
      if (stb_seen != 0) begin errors++; $display("FAIL abort stb: got %0d strobes expected 0", stb_seen); end
      if (dn_cyc !== 1'b0) begin errors++; $display("FAIL abort cyc: got %b expected 0", dn_cyc); end
      mprev = '0;
      rand_symbol();
      push_symbol();
      run(64, 80, 0, 1000);
      checks++;
      if (got_q.size() != 80) begin errors++; $display("FAIL abort count: got %0d expected 80", got_q.size()); end
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q[k] !== e) begin errors++; $display("FAIL abort[%0d]: got %h expected %h", k, got_q[k], e); end
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_reset_mid();
      logic [31:0] e;
      int n;
      mprev = '0;
      rand_symbol();
      push_symbol();
      run(64, 20, 0, 1000);
      checks++;
      if (got_q.size() != 20) begin errors++; $display("FAIL rstmid count: got %0d expected 20", got_q.size()); end
      for (int k = 0; k < 20; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q[k] !== e) begin errors++; $display("FAIL rstmid[%0d]: got %h expected %h", k, got_q[k], e); end
      end
      exp_q.delete();
      stim_q.delete();
      #1 rst_n = 1'b0;
      #1;
      checks += 4;
      if (dn_stb !== 1'b0) begin errors++; $display("FAIL rstmid stb: got %b expected 0", dn_stb); end
      if (dn_we !== 1'b0) begin errors++; $display("FAIL rstmid we: got %b expected 0", dn_we); end
      if (dn_cyc !== 1'b0) begin errors++; $display("FAIL rstmid cyc: got %b expected 0", dn_cyc); end
      if (dn_dat !== 32'h0) begin errors++; $display("FAIL rstmid dat: got %h expected 0", dn_dat); end
      up_stb = 1'b0;
      up_cyc = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mprev = '0;
      rand_symbol();
      push_symbol();
      run(64, 80, 0, 1000);
      checks++;
      if (got_q.size() != 80) begin errors++; $display("FAIL rstmid new_count: got %0d expected 80", got_q.size()); end
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q[k] !== e) begin errors++; $display("FAIL rstmid new[%0d]: got %h expected %h", k, got_q[k], e); end
      end
      repeat (3) @(posedge clk);
   endtask

`ifdef ADD_CP_WINDOW_EN
   task automatic test_window();
      logic [31:0] e;
      int n;
      mprev = '0;
      rand_symbol();
      sym[0]  = {16'd100, 16'hFF9C};
      sym[48] = {16'd30, 16'hFFE1};
      push_symbol();
      rand_symbol();
      sym[48] = {16'd40, 16'hFFD8};
      push_symbol();
      run(128, 160, 0, 2000);
      checks++;
      if (got_q.size() != 160) begin
         errors++;
         $display("FAIL win count: got %0d expected 160", got_q.size());
      end else begin
         checks += 2;
         if (got_q[0] !== {16'd15, 16'hFFF0}) begin errors++; $display("FAIL win first_a: got %h expected 000ffff0", got_q[0]); end
         if (got_q[80] !== {16'd70, 16'hFFBA}) begin errors++; $display("FAIL win first_b: got %h expected 0046ffba", got_q[80]); end
      end
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q[k] !== e) begin errors++; $display("FAIL win[%0d]: got %h expected %h", k, got_q[k], e); end
      end
      repeat (3) @(posedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_ramp();
      test_backpressure();
      test_back_to_back();
      test_abort();
      test_reset_mid();
`ifdef ADD_CP_WINDOW_EN
      test_window();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
